// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch unit: datapath widths,
// default reset vector and the sequential PC step.
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
  localparam logic [XLEN-1:0] WORD_MASK        = 32'd3;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~WORD_MASK;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer between memory responses and decode. Supports a
// synchronous flush that overrides any push or pop in the same cycle.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ILEN,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & (~full | do_pop) & ~flush;
  assign head_data = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: credit-limited request issue, in-order response
// buffering, and redirect handling that drops stale in-flight responses.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instruction
);

  localparam int             CNT_W        = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  target_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   in_flight;
  logic             fifo_empty;
  logic             req_fire;
  logic             rsp_stale;
  logic             fifo_push;
  logic             fifo_pop;

  assign target_pc = align_word(redirect_pc);
  assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};

  // A request may only go out if its response is guaranteed a buffer slot.
  assign imem_req_valid = rst_n & ~redirect_valid & (in_flight < CREDIT_LIMIT);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_stale = (discard != '0);
  assign fifo_push = imem_rsp_valid & ~rsp_stale & ~redirect_valid;
  assign fifo_pop  = out_valid & out_ready & ~redirect_valid;
  assign out_valid = ~fifo_empty;
  assign out_pc    = head_pc;

  ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ILEN),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (imem_rsp_data),
    .pop       (fifo_pop),
    .flush     (redirect_valid),
    .head_data (out_instruction),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= target_pc;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + PC_INCR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc <= RESET_PC;
    end else if (redirect_valid) begin
      head_pc <= target_pc;
    end else if (fifo_pop) begin
      head_pc <= head_pc + PC_INCR;
    end
  end

  // Counts every request still owed a response, stale or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (req_fire && !imem_rsp_valid) begin
      outstanding <= outstanding + 1'b1;
    end else if (!req_fire && imem_rsp_valid && outstanding != '0) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  // On redirect everything still in flight becomes stale; a response
  // landing in the redirect cycle itself is already being thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= '0;
    end else if (redirect_valid) begin
      discard <= (imem_rsp_valid && outstanding != '0) ? outstanding - 1'b1 : outstanding;
    end else if (imem_rsp_valid && rsp_stale) begin
      discard <= discard - 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a latency-1 memory model with hold control and
// a scoreboard of expected fetch addresses checked against decode output.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int          DEPTH    = 3;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  int          checks = 0;
  int          failures = 0;
  int          req_count = 0;
  bit          mem_en = 1'b0;
  bit          await_first = 1'b0;
  logic [31:0] first_pc = 32'hDEAD_BEEF;
  logic [31:0] model_pc;
  logic [31:0] mem_q[$];
  logic [31:0] sb_q[$];

  ifetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {~addr[15:0], addr[15:0]} ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: memory answers, outputs are sampled mid-cycle, then
  // the bench waits for the edge and returns just after it.
  task automatic step();
    logic [31:0] exp_pc;
    if (mem_en && mem_q.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (redirect_valid) begin
      check("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
    end
    if (out_valid && out_ready && !redirect_valid) begin
      check("output_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_pc = sb_q.pop_front();
        check("out_pc", out_pc, exp_pc);
        check("out_instruction", out_instruction, instr_of(exp_pc));
        if (await_first) begin
          first_pc    = out_pc;
          await_first = 1'b0;
        end
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, model_pc);
      mem_q.push_back(imem_req_addr);
      sb_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      req_count++;
    end
    if (redirect_valid) begin
      sb_q.delete();
      model_pc    = redirect_pc & ~32'd3;
      await_first = 1'b1;
      first_pc    = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit req_rdy, input bit out_rdy, input bit mem_on, input int cycles);
    imem_req_ready = req_rdy;
    out_ready      = out_rdy;
    mem_en         = mem_on;
    for (int i = 0; i < cycles; i++) begin
      step();
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 60;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    mem_en         = 1'b1;
    while ((sb_q.size() != 0 || mem_q.size() != 0) && budget > 0) begin
      step();
      budget--;
    end
    check({tag, "_drain_in_time"}, 32'(budget > 0), 32'd1);
    check({tag, "_drain_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  // Memory shares rst_n, so its pending responses vanish with the DUT state.
  task automatic do_reset(input string tag);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_q.delete();
    sb_q.delete();
    #1;
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    check({tag, "_out_pc"}, out_pc, RESET_PC);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    model_pc    = RESET_PC;
    await_first = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] expected_first);
    check(tag, first_pc, expected_first);
  endtask

  initial begin
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;
    model_pc       = RESET_PC;
    #1;

    // Power-on reset and first request right after release
    do_reset("reset");
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    mem_en         = 1'b1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    // Streaming with latency-1 memory: outputs 0x0, 0x4, 0x8, ...
    apply_stimulus(1'b1, 1'b1, 1'b1, 12);
    drain("stream");

    // Decode stalled: only DEPTH requests may be issued
    req_count = 0;
    apply_stimulus(1'b1, 1'b0, 1'b1, 10);
    check("stall_req_count", 32'(req_count), 32'(DEPTH));
    check("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 6);
    drain("stall");

    // Redirect with two responses held in memory
    apply_stimulus(1'b1, 1'b1, 1'b0, 2);
    check("inflight_two_reqs", 32'(mem_q.size()), 32'd2);
    do_redirect(32'h0000_0100);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1);
    check("redirect_no_bypass", 32'(out_valid), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8);
    check_output("redirect_first_pc", 32'h0000_0100);
    drain("redirect_100");

    // Redirect to unaligned 0x203 together with a response and a pop
    apply_stimulus(1'b1, 1'b0, 1'b0, 3);
    check("credit_full_req_valid", 32'(imem_req_valid), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1);
    check("pre_redirect_out_valid", 32'(out_valid), 32'd1);
    check("pre_redirect_rsp_pending", 32'(mem_q.size()), 32'd2);
    out_ready = 1'b1;
    do_redirect(32'h0000_0203);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("redirect_fetch_addr", imem_req_addr, 32'h0000_0200);
    check("redirect_out_pc", out_pc, 32'h0000_0200);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8);
    check_output("redirect_203_first_pc", 32'h0000_0200);
    drain("redirect_203");

    // Back-to-back redirects: only the second target stream survives
    apply_stimulus(1'b1, 1'b1, 1'b1, 5);
    do_redirect(32'h0000_0040);
    do_redirect(32'h0000_0080);
    apply_stimulus(1'b1, 1'b1, 1'b1, 10);
    check_output("double_redirect_first_pc", 32'h0000_0080);
    drain("double_redirect");

    // Asynchronous reset in the middle of a stream
    apply_stimulus(1'b1, 1'b1, 1'b1, 5);
    do_reset("midreset");
    #1;
    check("midreset_restart_valid", 32'(imem_req_valid), 32'd1);
    check("midreset_restart_addr", imem_req_addr, RESET_PC);
    apply_stimulus(1'b1, 1'b1, 1'b1, 8);
    drain("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
